// File: rtl/throw_pkg.sv
// Shared definitions for the dog's projectile: controller state encoding,
// fixed-point format and the sprite size agreed with the draw stage.
// No ports.
package throw_pkg;
   typedef enum logic [1:0] {IDLE, FLIGHT, DONE} proj_state_t;

   localparam int FRAC_BITS     = 4;
   localparam int PROJ_DIAMETER = 30;
endpackage

// File: rtl/vga_pkg.sv
// Display geometry shared by the video pipeline.
// No ports: exports the active-area dimensions used by downstream blocks.
package vga_pkg;
   localparam int HOR_PIXELS = 800;
   localparam int VER_PIXELS = 600;
endpackage

// File: rtl/vblnk_edge.sv
// Rising-edge detector for the vertical blank signal; the pulse marks one
// video frame.
// Ports:
//   clk   in  pixel clock
//   rst   in  synchronous active-high reset (clears the history bit)
//   vblnk in  vertical blank level
//   tick  out high for the cycle where vblnk is high and was low last cycle
module vblnk_edge (
   input  logic clk,
   input  logic rst,
   input  logic vblnk,
   output logic tick
);

   logic vblnk_q;

   always_ff @(posedge clk) begin
      if (rst) vblnk_q <= 1'b0;
      else     vblnk_q <= vblnk;
   end

   assign tick = vblnk & ~vblnk_q;

endmodule

// File: rtl/projectile_dog_ctl.sv
// Trajectory controller for the dog's projectile. Latches a launch velocity
// on fire, then advances position once per frame under constant gravity
// until the target is hit, the projectile lands, leaves the screen or times
// out. Position feeds the draw stage directly.
// Ports:
//   clk, rst                 pixel clock, synchronous active-high reset
//   vblnk                    vertical blank; rising edge = frame tick
//   fire                     launch request (sampled only when idle)
//   vx0, vy0                 launch speed, 1/16 px per frame
//   tgt_x_min/max, tgt_y_max target box (x inclusive range, y <= top)
//   enable                   projectile visible
//   x_pos, y_pos             projectile position in px
//   busy                     flight in progress
//   hit, miss                one-cycle result pulses
module projectile_dog_ctl
   import throw_pkg::*;
   import vga_pkg::*;
#(
   parameter int X_START    = 100,
   parameter int Y_START    = 100,
   parameter int GRAVITY    = 2,
   parameter int GROUND_Y   = 30,
   parameter int MAX_FRAMES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vblnk,
   input  logic        fire,
   input  logic [7:0]  vx0,
   input  logic [7:0]  vy0,
   input  logic [11:0] tgt_x_min,
   input  logic [11:0] tgt_x_max,
   input  logic [11:0] tgt_y_max,
   output logic        enable,
   output logic [11:0] x_pos,
   output logic [11:0] y_pos,
   output logic        busy,
   output logic        hit,
   output logic        miss
);

   localparam logic [15:0]        X_START_FP = 16'(X_START << FRAC_BITS);
   localparam logic signed [16:0] Y_START_FP = 17'(Y_START << FRAC_BITS);
   localparam logic signed [16:0] GROUND_FP  = 17'(GROUND_Y << FRAC_BITS);
   localparam logic [11:0]        OOB_X      = 12'(HOR_PIXELS + 30);
   localparam logic [11:0]        GRAV_V     = 12'(GRAVITY);
   localparam logic [7:0]         LAST_FRAME = 8'(MAX_FRAMES);

   logic tick;

   vblnk_edge u_vblnk_edge (
      .clk   (clk),
      .rst   (rst),
      .vblnk (vblnk),
      .tick  (tick)
   );

   proj_state_t state, state_nxt;

   logic [15:0]        x_fp, x_nxt;
   logic signed [16:0] y_fp, y_nxt;
   logic signed [11:0] vy, vy_nxt;
   logic [7:0]         vx;
   logic [7:0]         frames, frames_nxt;
   logic               res_hit;
   logic               hit_c, landed_c, oob_c, tmo_c, end_c;

   // Next-frame kinematics and end tests, all on the updated values so the
   // result is decided in the same cycle the position is registered.
   always_comb begin
      x_nxt      = x_fp + {8'd0, vx};
      y_nxt      = y_fp + {{5{vy[11]}}, vy};
      vy_nxt     = vy - GRAV_V;
      frames_nxt = frames + 8'd1;
      hit_c      = (x_nxt[15:4] >= tgt_x_min) && (x_nxt[15:4] <= tgt_x_max) &&
                   !y_nxt[16] && (y_nxt[15:4] <= tgt_y_max);
      landed_c   = y_nxt < GROUND_FP;
      oob_c      = x_nxt[15:4] > OOB_X;
      tmo_c      = frames_nxt == LAST_FRAME;
      end_c      = hit_c | landed_c | oob_c | tmo_c;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      enable    = 1'b0;
      busy      = 1'b0;
      hit       = 1'b0;
      miss      = 1'b0;
      case (state)
         IDLE:   if (fire) state_nxt = FLIGHT;
         FLIGHT: begin
            enable = 1'b1;
            busy   = 1'b1;
            if (tick && end_c) state_nxt = DONE;
         end
         DONE: begin
            hit       = res_hit;
            miss      = ~res_hit;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Position only moves on a frame tick while in flight, so it is stable
   // across the active video area. A tick in the load cycle is dropped
   // because the load branch takes precedence.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_fp    <= X_START_FP;
         y_fp    <= Y_START_FP;
         vx      <= 8'd0;
         vy      <= 12'sd0;
         frames  <= 8'd0;
         res_hit <= 1'b0;
      end else if (state == IDLE) begin
         if (fire) begin
            x_fp   <= X_START_FP;
            y_fp   <= Y_START_FP;
            vx     <= vx0;
            vy     <= {4'd0, vy0};
            frames <= 8'd0;
         end
      end else if (state == FLIGHT && tick) begin
         x_fp    <= x_nxt;
         y_fp    <= y_nxt;
         vy      <= vy_nxt;
         frames  <= frames_nxt;
         res_hit <= hit_c;
      end
   end

   assign x_pos = x_fp[15:4];
   assign y_pos = y_fp[16] ? 12'd0 : y_fp[15:4];

endmodule

// File: tb/tb_projectile_dog_ctl.sv
// Bench for projectile_dog_ctl: directed scenarios plus randomized flights,
// all compared against a trajectory model kept in plain integer arithmetic.
module tb_projectile_dog_ctl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        vblnk = 1'b0;
   logic        fire = 1'b0;
   logic        fire_g0 = 1'b0;
   logic [7:0]  vx0 = 8'd0, vy0 = 8'd0, zero8 = 8'd0;
   logic [11:0] tx_min = 12'd4000, tx_max = 12'd4095, ty_max = 12'd0;

   logic        enable, busy, hit, miss;
   logic [11:0] x_pos, y_pos;
   logic        en_g0, busy_g0, hit_g0, miss_g0;
   logic [11:0] x_g0, y_g0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   projectile_dog_ctl dut (
      .clk(clk), .rst(rst), .vblnk(vblnk), .fire(fire),
      .vx0(vx0), .vy0(vy0),
      .tgt_x_min(tx_min), .tgt_x_max(tx_max), .tgt_y_max(ty_max),
      .enable(enable), .x_pos(x_pos), .y_pos(y_pos),
      .busy(busy), .hit(hit), .miss(miss)
   );

   // Gravity-free copy for the timeout scenario.
   projectile_dog_ctl #(.GRAVITY(0)) u_g0 (
      .clk(clk), .rst(rst), .vblnk(vblnk), .fire(fire_g0),
      .vx0(zero8), .vy0(zero8),
      .tgt_x_min(tx_min), .tgt_x_max(tx_max), .tgt_y_max(ty_max),
      .enable(en_g0), .x_pos(x_g0), .y_pos(y_g0),
      .busy(busy_g0), .hit(hit_g0), .miss(miss_g0)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Reference model: position/velocity in 1/16 px integers.
   int m_x = 1600, m_y = 1600, m_vx = 0, m_vy = 0, m_fr = 0;
   bit m_fly = 0, m_done = 0, m_done_hit = 0, m_vq = 0;

   task automatic mdl_clock();
      bit tk, h;
      int px, py;
      tk = vblnk && !m_vq;
      if (rst) begin
         m_x = 1600; m_y = 1600; m_fly = 0; m_done = 0; m_done_hit = 0; m_vq = 0;
      end else begin
         if (m_done) m_done = 0;
         else if (!m_fly) begin
            if (fire) begin
               m_x = 1600; m_y = 1600; m_vx = vx0; m_vy = vy0; m_fr = 0; m_fly = 1;
            end
         end else if (tk) begin
            m_x += m_vx; m_y += m_vy; m_vy -= 2; m_fr++;
            px = m_x / 16;
            py = (m_y >= 0) ? m_y / 16 : 0;
            h = (px >= tx_min) && (px <= tx_max) && (m_y >= 0) && (py <= ty_max);
            if (h || m_y < 30 * 16 || px > 800 + 30 || m_fr == 255) begin
               m_fly = 0; m_done = 1; m_done_hit = h;
            end
         end
         m_vq = vblnk;
      end
   endtask

   task automatic cmp_all();
      chk("enable", enable, m_fly);
      chk("busy", busy, m_fly);
      chk("hit", hit, m_done && m_done_hit);
      chk("miss", miss, m_done && !m_done_hit);
      chk("x_pos", x_pos, (m_x / 16) & 12'hFFF);
      chk("y_pos", y_pos, (m_y < 0) ? 0 : (m_y / 16) & 12'hFFF);
   endtask

   task automatic cyc(input bit v, input bit f);
      vblnk = v;
      fire  = f;
      @(posedge clk);
      mdl_clock();
      #1;
      cmp_all();
   endtask

   logic       s_hit, s_miss, s_en;
   logic [11:0] s_x, s_y;

   task automatic frame_obs();
      cyc(1, 0);
      s_hit = hit; s_miss = miss; s_en = enable; s_x = x_pos; s_y = y_pos;
      cyc(0, 0);
      cyc(0, 0);
   endtask

   task automatic run_random_flight(input int maxf);
      int n = 0;
      int lo, hi;
      while (m_fly && n < maxf) begin
         lo = $urandom_range(1, 4);
         hi = $urandom_range(1, 3);
         repeat (lo) cyc(0, m_fly && ($urandom_range(0, 9) == 0));
         repeat (hi) begin
            if ($urandom_range(0, 5) == 0) vx0 = 8'($urandom);
            cyc(1, m_fly && ($urandom_range(0, 7) == 0));
         end
         n++;
      end
      chk("flight_end", m_fly, 0);
      cyc(0, 0);
      cyc(0, 0);
   endtask

   initial begin
      int end_t;

      // Reset
      rst = 1;
      cyc(0, 0);
      cyc(0, 0);
      chk("rst_enable", enable, 0);
      chk("rst_busy", busy, 0);
      chk("rst_x", x_pos, 100);
      chk("rst_y", y_pos, 100);
      chk("rst_hit", hit, 0);
      chk("rst_miss", miss, 0);
      rst = 0;
      cyc(0, 0);

      // Nominal miss, with an ignored fire mid-flight
      vx0 = 8'd32; vy0 = 8'd64; tx_min = 12'd4000; tx_max = 12'd4095; ty_max = 12'd0;
      cyc(0, 1);
      chk("launch_enable", enable, 1);
      cyc(0, 0);
      end_t = 0;
      for (int t = 1; t <= 120; t++) begin
         frame_obs();
         if (t == 1) begin
            chk("nom_t1_x", s_x, 102);
            chk("nom_t1_y", s_y, 104);
         end
         if (t == 40) begin
            vx0 = 8'd200;
            cyc(0, 1);
            chk("fire_ign_busy", busy, 1);
            vx0 = 8'd32;
         end
         if (t == 41) chk("fire_ign_x", s_x, 182);
         if (t == 79) begin
            chk("nom_t79_y", s_y, 30);
            chk("nom_t79_en", s_en, 1);
         end
         if (s_miss || s_hit) begin
            end_t = t;
            break;
         end
      end
      chk("nom_end_tick", end_t, 80);
      chk("nom_end_miss", s_miss, 1);
      chk("nom_end_x", s_x, 260);
      chk("nom_end_y", s_y, 25);
      chk("nom_end_en", s_en, 0);

      // Hit
      tx_min = 12'd150; tx_max = 12'd170; ty_max = 12'd200;
      cyc(0, 1);
      cyc(0, 0);
      end_t = 0;
      for (int t = 1; t <= 60; t++) begin
         frame_obs();
         if (t == 24) begin
            chk("hit_t24_x", s_x, 148);
            chk("hit_t24_hit", s_hit, 0);
         end
         if (s_miss || s_hit) begin
            end_t = t;
            break;
         end
      end
      chk("hit_tick", end_t, 25);
      chk("hit_pulse", s_hit, 1);
      chk("hit_nomiss", s_miss, 0);
      chk("hit_x", s_x, 150);
      chk("hit_y", s_y, 162);

      // Frame edge: tick in load cycle, then vblnk held high
      tx_min = 12'd4000; tx_max = 12'd4095;
      cyc(0, 0);
      cyc(1, 1);
      repeat (499) cyc(1, 0);
      chk("hold_x", x_pos, 100);
      chk("hold_y", y_pos, 100);
      chk("hold_en", enable, 1);
      cyc(0, 0);
      cyc(1, 0);
      chk("edge_x", x_pos, 102);
      chk("edge_y", y_pos, 104);
      cyc(0, 0);

      // Reset on tick 10
      for (int t = 2; t <= 9; t++) frame_obs();
      rst = 1;
      cyc(1, 0);
      rst = 0;
      chk("mrst_en", enable, 0);
      chk("mrst_x", x_pos, 100);
      chk("mrst_y", y_pos, 100);
      chk("mrst_hit", hit, 0);
      chk("mrst_miss", miss, 0);
      cyc(0, 0);

      // Timeout on the gravity-free instance
      fire_g0 = 1;
      cyc(0, 0);
      fire_g0 = 0;
      cyc(0, 0);
      chk("tmo_launch", en_g0, 1);
      for (int t = 1; t <= 255; t++) begin
         cyc(1, 0);
         if (t < 255) begin
            chk("tmo_en", en_g0, 1);
            chk("tmo_early_miss", miss_g0, 0);
         end else begin
            chk("tmo_miss", miss_g0, 1);
            chk("tmo_hit", hit_g0, 0);
            chk("tmo_en_end", en_g0, 0);
            chk("tmo_x", x_g0, 100);
            chk("tmo_y", y_g0, 100);
         end
         cyc(0, 0);
      end
      cyc(0, 0);
      chk("tmo_idle", busy_g0, 0);

      // Randomized flights
      for (int r = 0; r < 12; r++) begin
         vx0 = 8'($urandom);
         vy0 = 8'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            tx_min = 12'($urandom_range(100, 400));
            tx_max = tx_min + 12'($urandom_range(0, 60));
            ty_max = 12'($urandom_range(0, 300));
         end else begin
            tx_min = 12'($urandom_range(0, 4095));
            tx_max = 12'($urandom_range(0, 4095));
            ty_max = 12'($urandom_range(0, 4095));
         end
         repeat ($urandom_range(1, 5)) cyc(0, 0);
         cyc($urandom_range(0, 1), 1);
         run_random_flight(300);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
